// File: rtl/branch_pkg.sv
// branch_pkg: shared branch-tag types for the allocator, issue queue and checkers
// Contents: BID_W/NUM_TAGS sizing, bid_t tag id, tag_mask_t one-bit-per-tag mask,
// cnt_t occupancy count, sat_add saturating 32-bit accumulate for perf counters.
package branch_pkg;
  localparam int BID_W    = 3;
  localparam int NUM_TAGS = 2 ** BID_W;
  typedef logic [BID_W-1:0]    bid_t;
  typedef logic [NUM_TAGS-1:0] tag_mask_t;
  typedef logic [BID_W:0]      cnt_t;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/btag_range_mask.sv
// btag_range_mask: combinational mask of tags in the wrapping half-open range [from, to)
// Ports: from (first tag), to (one past last tag), mask (bit i set when i is in range).
// from == to yields an empty mask; callers handle the all-tags case themselves.
import branch_pkg::*;
module btag_range_mask (
  input  bid_t      from,
  input  bid_t      to,
  output tag_mask_t mask
);
  for (genvar i = 0; i < NUM_TAGS; i++) begin : g_bit
    assign mask[i] = bid_t'(bid_t'(i) - from) < bid_t'(to - from);
  end
endmodule

// File: rtl/branch_tag_alloc.sv
// branch_tag_alloc: branch-ID pool with dual-lane allocation, in-order retire and mispredict flush
// Ports: clk, rst (async, active low); alloc_req_1/2 -> alloc_gnt_1/2 and lane_bid_1/2 (comb);
// resolve_vld/resolve_bid/resolve_mispr from the branch unit; registered flush_en/flush_id/flush_mask;
// branch_full, branch_empty, live_cnt occupancy status.
// Optional: BTAG_PERF_EN adds saturating perf_alloc_cnt, perf_mispr_cnt, perf_full_cyc.
import branch_pkg::*;
module branch_tag_alloc (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req_1,
  input  logic       alloc_req_2,
  output logic       alloc_gnt_1,
  output logic       alloc_gnt_2,
  output bid_t       lane_bid_1,
  output bid_t       lane_bid_2,
  input  logic       resolve_vld,
  input  bid_t       resolve_bid,
  input  logic       resolve_mispr,
  output logic       flush_en,
  output bid_t       flush_id,
  output tag_mask_t  flush_mask,
  output logic       branch_full,
  output logic       branch_empty,
  output logic [BID_W:0] live_cnt
`ifdef BTAG_PERF_EN
  ,
  output logic [31:0] perf_alloc_cnt,
  output logic [31:0] perf_mispr_cnt,
  output logic [31:0] perf_full_cyc
`endif
);
  bid_t head, tail;
  cnt_t count, free, kept, grants, retired;
  tag_mask_t resolved, span, live_mask, sq_mask, pop_mask;
  logic full, live, kill, pop1, pop2;
  btag_range_mask u_live (.from(head), .to(tail), .mask(span));
  btag_range_mask u_sq (.from(bid_t'(resolve_bid + 1'b1)), .to(tail), .mask(sq_mask));
  // head == tail is ambiguous; the count disambiguates full from empty
  assign full        = count == cnt_t'(NUM_TAGS);
  assign live_mask   = full ? '1 : span;
  assign live        = resolve_vld & live_mask[resolve_bid];
  assign kill        = live & resolve_mispr;
  assign free        = cnt_t'(NUM_TAGS) - count;
  assign alloc_gnt_1 = alloc_req_1 & (free != '0) & ~kill;
  assign alloc_gnt_2 = alloc_req_2 & ~kill & (alloc_req_1 ? alloc_gnt_1 & (free >= cnt_t'(2)) : free != '0);
  assign lane_bid_1  = alloc_gnt_1 ? tail : tail - 1'b1;
  assign lane_bid_2  = alloc_gnt_2 ? tail + bid_t'(alloc_gnt_1) : lane_bid_1;
  // tags from head up to and including the mispredicted one survive the squash
  assign kept        = cnt_t'(bid_t'(resolve_bid - head)) + cnt_t'(1);
  assign pop1        = (count != '0) & resolved[head];
  // the second pop must not take a tag being squashed this cycle
  assign pop2        = pop1 & (count >= cnt_t'(2)) & resolved[bid_t'(head + 1'b1)] & ~(kill & (resolve_bid == head));
  assign retired     = cnt_t'(pop1) + cnt_t'(pop2);
  assign grants      = cnt_t'(alloc_gnt_1) + cnt_t'(alloc_gnt_2);
  assign pop_mask    = (pop1 ? tag_mask_t'(1) << head : '0) | (pop2 ? tag_mask_t'(1) << bid_t'(head + 1'b1) : '0);
  assign branch_full  = full;
  assign branch_empty = count == '0;
  assign live_cnt     = count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      resolved   <= '0;
      flush_en   <= 1'b0;
      flush_id   <= '0;
      flush_mask <= '0;
    end else begin
      head       <= head + bid_t'(retired);
      tail       <= kill ? bid_t'(resolve_bid + 1'b1) : tail + bid_t'(grants);
      count      <= (kill ? kept : count) + grants - retired;
      resolved   <= (resolved | (live ? tag_mask_t'(1) << resolve_bid : '0)) & ~(kill ? sq_mask : '0) & ~pop_mask;
      flush_en   <= kill;
      flush_id   <= kill ? resolve_bid : '0;
      flush_mask <= kill ? sq_mask : '0;
    end
`ifdef BTAG_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_alloc_cnt <= '0;
      perf_mispr_cnt <= '0;
      perf_full_cyc  <= '0;
    end else begin
      perf_alloc_cnt <= sat_add(perf_alloc_cnt, grants[1:0]);
      perf_mispr_cnt <= sat_add(perf_mispr_cnt, {1'b0, kill});
      perf_full_cyc  <= sat_add(perf_full_cyc, {1'b0, full & (alloc_req_1 | alloc_req_2)});
    end
`endif
endmodule
